// File: rtl/hilo_muldiv_if.sv
// Request/response bundle between the EX stage and the HI/LO multiply/divide unit.
// The pipeline side is the master; the unit is the slave.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             stall;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             done;

    modport master (
        output start, op, src_a, src_b, cancel,
        input  stall, hi_we, lo_we, hi_o, lo_o, done
    );

    modport slave (
        input  start, op, src_a, src_b, cancel,
        output stall, hi_we, lo_we, hi_o, lo_o, done
    );
endinterface

// File: rtl/hilo_muldiv.sv
// Iterative shift-add multiplier / restoring divider feeding the HI/LO write port.
// Signed ops run on magnitudes and are sign-corrected in a single FIX cycle.
module hilo_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         resetn,
    hilo_muldiv_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_WB} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_r, lo_r, opb;
    logic             neg_hi, neg_lo, is_mul;
    logic             hi_we_q, lo_we_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic               idle, accept, mt_accept, last_iter, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs, trial, fix_hi, fix_lo;
    logic [WIDTH:0]     add_sum, shifted;
    logic [2*WIDTH-1:0] prod_fix;

    assign idle      = (state == S_IDLE);
    assign accept    = idle & bus.start & ~bus.cancel & ~bus.op[2];
    assign mt_accept = idle & bus.start & ~bus.cancel & (bus.op[2:1] == 2'b10);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // op[0] set means the unsigned variant, so only MULT/DIV take magnitudes
    assign a_neg = ~bus.op[0] & bus.src_a[WIDTH-1];
    assign b_neg = ~bus.op[0] & bus.src_b[WIDTH-1];
    assign a_abs = a_neg ? -bus.src_a : bus.src_a;
    assign b_abs = b_neg ? -bus.src_b : bus.src_b;

    assign add_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opb} : '0);
    assign shifted = {hi_r, lo_r[WIDTH-1]};
    // partial remainder stays below the divisor, so the low WIDTH bits are exact
    assign trial   = shifted[WIDTH-1:0] - opb;

    assign prod_fix = neg_lo ? -{hi_r, lo_r} : {hi_r, lo_r};
    assign fix_hi   = is_mul ? prod_fix[2*WIDTH-1:WIDTH] : (neg_hi ? -hi_r : hi_r);
    assign fix_lo   = is_mul ? prod_fix[WIDTH-1:0]       : (neg_lo ? -lo_r : lo_r);

    assign bus.stall = resetn & ((state == S_MUL) | (state == S_DIV) | (state == S_FIX) | accept);
    assign bus.hi_we = hi_we_q;
    assign bus.lo_we = lo_we_q;
    assign bus.done  = done_q;
    assign bus.hi_o  = hi_q;
    assign bus.lo_o  = lo_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nx;
    end

    // NOTE: next state defaults to the current state before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:       if (accept) state_nx = bus.op[1] ? S_DIV : S_MUL;
            S_MUL, S_DIV: if (bus.cancel) state_nx = S_IDLE;
                          else if (last_iter) state_nx = S_FIX;
            S_FIX:        state_nx = bus.cancel ? S_IDLE : S_WB;
            S_WB:         state_nx = S_IDLE;
            default:      state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt     <= '0;
            hi_r    <= '0;
            lo_r    <= '0;
            opb     <= '0;
            neg_hi  <= 1'b0;
            neg_lo  <= 1'b0;
            is_mul  <= 1'b0;
            hi_we_q <= 1'b0;
            lo_we_q <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            hi_we_q <= 1'b0;
            lo_we_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        hi_r   <= '0;
                        is_mul <= ~bus.op[1];
                        if (bus.op[1] && bus.src_b == '0) begin
                            // divide by zero: raw dividend through unsigned path leaves lo=~0, hi=src_a
                            lo_r   <= bus.src_a;
                            opb    <= '0;
                            neg_lo <= 1'b0;
                            neg_hi <= 1'b0;
                        end else if (bus.op[1]) begin
                            lo_r   <= a_abs;
                            opb    <= b_abs;
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg;
                        end else begin
                            lo_r   <= b_abs;
                            opb    <= a_abs;
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= a_neg ^ b_neg;
                        end
                    end else if (mt_accept) begin
                        done_q <= 1'b1;
                        if (bus.op[0]) begin
                            lo_q    <= bus.src_a;
                            lo_we_q <= 1'b1;
                        end else begin
                            hi_q    <= bus.src_a;
                            hi_we_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    hi_r <= add_sum[WIDTH:1];
                    lo_r <= {add_sum[0], lo_r[WIDTH-1:1]};
                    cnt  <= cnt + CNT_W'(1);
                end
                S_DIV: begin
                    if (shifted >= {1'b0, opb}) begin
                        hi_r <= trial;
                        lo_r <= {lo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        hi_r <= shifted[WIDTH-1:0];
                        lo_r <= {lo_r[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_W'(1);
                end
                S_FIX: begin
                    if (!bus.cancel) begin
                        hi_q    <= fix_hi;
                        lo_q    <= fix_lo;
                        hi_we_q <= 1'b1;
                        lo_we_q <= 1'b1;
                        done_q  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed corner cases plus random ops
// compared against an arithmetic reference of the HI/LO results and cycle timing.
module tb_hilo_muldiv;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    hilo_muldiv_if #(.WIDTH(32)) bus ();

    hilo_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {hi, lo} as the architecture defines it, from plain integer arithmetic
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2: if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                  else return {32'(sa % sb), 32'(sa / sb)};
            default: if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                     else return {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction

    task automatic run_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        r = ref_result(op, a, b);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b; bus.cancel = 1'b0;
        #1 check("acc_stall", 64'(bus.stall), 64'(1));
        for (int k = 1; k <= 34; k++) begin
            tick();
            if (k < 34) begin
                check("busy_stall", 64'(bus.stall), 64'(1));
                check("busy_done", 64'(bus.done), 64'(0));
                check("busy_hi_hold", 64'(bus.hi_o), 64'(exp_hi));
                bus.start = 1'($urandom_range(0, 1));
                bus.op    = 3'($urandom_range(0, 7));
                bus.src_a = $urandom;
                bus.src_b = $urandom;
            end
        end
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        check("wb_hi_we", 64'(bus.hi_we), 64'(1));
        check("wb_lo_we", 64'(bus.lo_we), 64'(1));
        check("wb_done", 64'(bus.done), 64'(1));
        check("wb_stall", 64'(bus.stall), 64'(0));
        check("wb_hi", 64'(bus.hi_o), 64'(exp_hi));
        check("wb_lo", 64'(bus.lo_o), 64'(exp_lo));
        bus.start = 1'b0;
        tick();
        check("post_done", 64'(bus.done), 64'(0));
        check("post_hi_we", 64'(bus.hi_we), 64'(0));
        check("post_hi", 64'(bus.hi_o), 64'(exp_hi));
        check("post_lo", 64'(bus.lo_o), 64'(exp_lo));
    endtask

    task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
        bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = $urandom; bus.cancel = 1'b0;
        #1 check("mt_acc_stall", 64'(bus.stall), 64'(0));
        tick();
        if (op == 3'd4) exp_hi = a;
        else            exp_lo = a;
        bus.start = 1'b0;
        check("mt_hi_we", 64'(bus.hi_we), 64'(op == 3'd4));
        check("mt_lo_we", 64'(bus.lo_we), 64'(op == 3'd5));
        check("mt_done", 64'(bus.done), 64'(1));
        check("mt_hi", 64'(bus.hi_o), 64'(exp_hi));
        check("mt_lo", 64'(bus.lo_o), 64'(exp_lo));
        #1 check("mt_stall", 64'(bus.stall), 64'(0));
        tick();
        check("mt_post_done", 64'(bus.done), 64'(0));
    endtask

    task automatic run_ignored(input logic [2:0] op);
        bus.start = 1'b1; bus.op = op; bus.src_a = $urandom; bus.src_b = $urandom; bus.cancel = 1'b0;
        #1 check("ign_stall", 64'(bus.stall), 64'(0));
        tick();
        bus.start = 1'b0;
        check("ign_done", 64'(bus.done), 64'(0));
        check("ign_we", 64'({bus.hi_we, bus.lo_we}), 64'(0));
        check("ign_hi", 64'(bus.hi_o), 64'(exp_hi));
        check("ign_lo", 64'(bus.lo_o), 64'(exp_lo));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_hi = '0;
        exp_lo = '0;
        resetn = 1'b0;
        bus.start = 1'b0; bus.op = 3'd0; bus.src_a = '0; bus.src_b = '0; bus.cancel = 1'b0;

        // reset: outputs cleared, stall held low even with a valid request
        tick();
        bus.start = 1'b1; bus.op = 3'd0;
        #1 check("rst_stall", 64'(bus.stall), 64'(0));
        tick();
        check("rst_hi", 64'(bus.hi_o), 64'(0));
        check("rst_lo", 64'(bus.lo_o), 64'(0));
        check("rst_we", 64'({bus.hi_we, bus.lo_we, bus.done}), 64'(0));
        bus.start = 1'b0;
        resetn = 1'b1;
        tick();

        // directed corner cases
        run_mdu(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_mdu(3'd0, 32'hFFFF_FFFD, 32'd5);
        run_mdu(3'd2, 32'hFFFF_FFF9, 32'd2);
        run_mdu(3'd3, 32'd7, 32'd0);
        run_mdu(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_mdu(3'd2, 32'hFFFF_FFF9, 32'd0);
        run_mt(3'd4, 32'h1234_5678);
        run_mt(3'd5, 32'hCAFE_F00D);
        run_ignored(3'd6);
        run_ignored(3'd7);

        // cancel in IDLE suppresses the request
        bus.start = 1'b1; bus.op = 3'd0; bus.cancel = 1'b1;
        #1 check("idle_cancel_stall", 64'(bus.stall), 64'(0));
        tick();
        bus.start = 1'b0; bus.cancel = 1'b0;
        #1 check("idle_cancel_state", 64'(bus.stall), 64'(0));
        check("idle_cancel_done", 64'(bus.done), 64'(0));

        // cancel a DIVU at T+10, restart at T+11
        bus.start = 1'b1; bus.op = 3'd3; bus.src_a = 32'd100; bus.src_b = 32'd7;
        #1 check("cx_acc_stall", 64'(bus.stall), 64'(1));
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < 10; k++) begin
            check("cx_busy_done", 64'(bus.done), 64'(0));
            tick();
        end
        bus.cancel = 1'b1;
        #1 check("cx_stall_t10", 64'(bus.stall), 64'(1));
        tick();
        bus.cancel = 1'b0;
        #1 check("cx_stall_t11", 64'(bus.stall), 64'(0));
        check("cx_done_t11", 64'(bus.done), 64'(0));
        run_mdu(3'd3, 32'd100, 32'd7);

        // reset at T+20 of a MULT discards it
        bus.start = 1'b1; bus.op = 3'd0; bus.src_a = $urandom; bus.src_b = $urandom;
        #1 check("rx_acc_stall", 64'(bus.stall), 64'(1));
        tick();
        bus.start = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        resetn = 1'b0;
        bus.start = 1'b1;
        #1 check("rx_stall_forced", 64'(bus.stall), 64'(0));
        tick();
        exp_hi = '0;
        exp_lo = '0;
        check("rx_hi", 64'(bus.hi_o), 64'(0));
        check("rx_lo", 64'(bus.lo_o), 64'(0));
        check("rx_we", 64'({bus.hi_we, bus.lo_we, bus.done}), 64'(0));
        bus.start = 1'b0;
        resetn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            check("rx_no_write", 64'(bus.done), 64'(0));
            check("rx_idle_stall", 64'(bus.stall), 64'(0));
        end

        // random mix against the reference
        for (int n = 0; n < 24; n++) begin
            logic [2:0]  rop;
            logic [31:0] ra, rb;
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (rop < 3'd4)      run_mdu(rop, ra, rb);
            else if (rop < 3'd6) run_mt(rop, ra);
            else                 run_ignored(rop);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
